// File: rtl/pcs_pkg.sv
// Shared PCS transmit definitions: ordered-set request encoding, special
// code-group octets and the code-group generator state type.
package pcs_pkg;

    typedef logic [2:0] os_t;

    localparam os_t OS_I = 3'd0;
    localparam os_t OS_S = 3'd1;
    localparam os_t OS_D = 3'd2;
    localparam os_t OS_T = 3'd3;
    localparam os_t OS_R = 3'd4;
    localparam os_t OS_V = 3'd5;

    // Octet values fed to the encoder together with is_k.
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t GEN_CG = 2'd0;
    localparam fsm_state_t IDLE_K = 2'd1;
    localparam fsm_state_t IDLE_D = 2'd2;

endpackage

// File: rtl/tx_code_group_if.sv
// Ordered-set request / code-group bus between TX_OS (master) and the
// code-group generator (slave).
interface tx_code_group_if;

    logic [2:0] tx_o_set;
    logic [7:0] TXD;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       TX_OSET_indicate;
    logic       tx_disparity;

    modport master (
        output tx_o_set, TXD,
        input  tx_code_group, tx_even, TX_OSET_indicate, tx_disparity
    );

    modport slave (
        input  tx_o_set, TXD,
        output tx_code_group, tx_even, TX_OSET_indicate, tx_disparity
    );

endinterface

// File: rtl/enc_8b10b.sv
// Combinational 8B/10B encoder: 5b/6b and 3b/4b sub-blocks with running
// disparity threaded from the 6b block into the 4b block.
module enc_8b10b (
    input  logic [7:0] octet,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code10,
    output logic       rd_out
);

    // abcdei for RD-; the RD+ form is the complement when not neutral.
    function automatic logic [5:0] six_rdm(input logic [4:0] x);
        case (x)
            5'd0:  six_rdm = 6'b100111;  5'd1:  six_rdm = 6'b011101;
            5'd2:  six_rdm = 6'b101101;  5'd3:  six_rdm = 6'b110001;
            5'd4:  six_rdm = 6'b110101;  5'd5:  six_rdm = 6'b101001;
            5'd6:  six_rdm = 6'b011001;  5'd7:  six_rdm = 6'b111000;
            5'd8:  six_rdm = 6'b111001;  5'd9:  six_rdm = 6'b100101;
            5'd10: six_rdm = 6'b010101;  5'd11: six_rdm = 6'b110100;
            5'd12: six_rdm = 6'b001101;  5'd13: six_rdm = 6'b101100;
            5'd14: six_rdm = 6'b011100;  5'd15: six_rdm = 6'b010111;
            5'd16: six_rdm = 6'b011011;  5'd17: six_rdm = 6'b100011;
            5'd18: six_rdm = 6'b010011;  5'd19: six_rdm = 6'b110010;
            5'd20: six_rdm = 6'b001011;  5'd21: six_rdm = 6'b101010;
            5'd22: six_rdm = 6'b011010;  5'd23: six_rdm = 6'b111010;
            5'd24: six_rdm = 6'b110011;  5'd25: six_rdm = 6'b100110;
            5'd26: six_rdm = 6'b010110;  5'd27: six_rdm = 6'b110110;
            5'd28: six_rdm = 6'b001110;  5'd29: six_rdm = 6'b101110;
            5'd30: six_rdm = 6'b011110;  default: six_rdm = 6'b101011;
        endcase
    endfunction

    // fghj for RD- ahead of the 4b block; K columns differ on y=1,2,5,6.
    function automatic logic [3:0] four_rdm(input logic [2:0] y, input logic k);
        case (y)
            3'd0: four_rdm = 4'b1011;
            3'd1: four_rdm = k ? 4'b0110 : 4'b1001;
            3'd2: four_rdm = k ? 4'b1010 : 4'b0101;
            3'd3: four_rdm = 4'b1100;
            3'd4: four_rdm = 4'b1101;
            3'd5: four_rdm = k ? 4'b0101 : 4'b1010;
            3'd6: four_rdm = k ? 4'b1001 : 4'b0110;
            default: four_rdm = 4'b1110;
        endcase
    endfunction

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six_base, six;
    logic [3:0] four_base, four;
    logic       rd_mid, use_a7, comp4;

    assign x = octet[4:0];
    assign y = octet[7:5];

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        six_base  = six_rdm(x);
        four_base = four_rdm(y, is_k);
        use_a7    = 1'b0;

        if (is_k && x == 5'd28)
            six_base = 6'b001111;

        six    = (rd_in && (($countones(six_base) != 3) || six_base == 6'b111000))
                 ? ~six_base : six_base;
        rd_mid = ($countones(six) != 3) ? ~rd_in : rd_in;

        // Alternate Dx.7 avoids a run of five identical bits across the boundary.
        if (y == 3'd7) begin
            use_a7 = is_k
                  || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                  || ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
            if (use_a7)
                four_base = 4'b0111;
        end

        comp4  = is_k ? rd_mid
                      : (rd_mid && (($countones(four_base) != 2) || four_base == 4'b1100));
        four   = comp4 ? ~four_base : four_base;
        rd_out = ($countones(four) != 2) ? ~rd_mid : rd_mid;
        code10 = {six, four};
    end

endmodule

// File: rtl/tx_code_group.sv
// PCS transmit code-group generator: turns ordered-set requests into
// registered 10-bit code-groups with idle alignment and running disparity.
module tx_code_group
    import pcs_pkg::*;
(
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    tx_code_group_if.slave   bus
);

    fsm_state_t state_q, state_d;
    logic [9:0] code_q;
    logic       even_q;
    logic       ind_q, ind_d;
    logic       rd_q;

    logic [7:0] enc_octet;
    logic       enc_is_k;
    logic [9:0] enc_code;
    logic       enc_rd;

    enc_8b10b u_enc (
        .octet  (enc_octet),
        .is_k   (enc_is_k),
        .rd_in  (rd_q),
        .code10 (enc_code),
        .rd_out (enc_rd)
    );

    always_comb begin
        state_d   = GEN_CG;
        enc_octet = K30_7;
        enc_is_k  = 1'b1;
        ind_d     = 1'b1;

        if (state_q == IDLE_K) begin
            // K28.5 always flips RD, so rd_q=0 here means RD was + before it.
            state_d   = IDLE_D;
            enc_is_k  = 1'b0;
            enc_octet = rd_q ? D16_2 : D5_6;
        end else begin
            case (bus.tx_o_set)
                OS_I: begin
                    if (even_q) begin
                        state_d   = IDLE_K;
                        enc_octet = K28_5;
                        ind_d     = 1'b0;
                    end else begin
                        enc_octet = K23_7;
                    end
                end
                OS_S:    enc_octet = K27_7;
                OS_T:    enc_octet = K29_7;
                OS_R:    enc_octet = K23_7;
                OS_D: begin
                    enc_is_k  = 1'b0;
                    enc_octet = bus.TXD;
                end
                default: enc_octet = K30_7;
            endcase
        end
    end

    // NOTE: the code-group register is reset like all other state so the line idles at 10'h000.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= GEN_CG;
            code_q  <= 10'h000;
            even_q  <= 1'b1;
            ind_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every register see pre-edge values.
            state_q <= state_d;
            code_q  <= enc_code;
            even_q  <= ~even_q;
            ind_q   <= ind_d;
            rd_q    <= enc_rd;
        end
    end

    assign bus.tx_code_group    = code_q;
    assign bus.tx_even          = even_q;
    assign bus.TX_OSET_indicate = ind_q;
    assign bus.tx_disparity     = rd_q;

endmodule

// File: tb/tb_tx_code_group.sv
// Directed self-checking bench for tx_code_group with hand-computed code-groups.
module tb_tx_code_group;
    import pcs_pkg::*;

    logic GTX_CLK;
    logic mr_main_reset;
    int   checks;
    int   errors;
    logic exp_even;

    tx_code_group_if bus ();

    tx_code_group dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .bus           (bus.slave)
    );

    initial GTX_CLK = 1'b0;
    always #4 GTX_CLK = ~GTX_CLK;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".code"}, bus.tx_code_group, 10'h000);
        check({tag, ".rd"},   {9'd0, bus.tx_disparity},     10'd0);
        check({tag, ".even"}, {9'd0, bus.tx_even},          10'd1);
        check({tag, ".ind"},  {9'd0, bus.TX_OSET_indicate}, 10'd0);
    endtask

    task automatic step(input string tag, input logic [2:0] os, input logic [7:0] txd,
                        input logic [9:0] exp_code, input logic exp_ind, input logic exp_rd);
        bus.tx_o_set = os;
        bus.TXD      = txd;
        @(posedge GTX_CLK);
        #1;
        exp_even = ~exp_even;
        check({tag, ".code"}, bus.tx_code_group, exp_code);
        check({tag, ".ind"},  {9'd0, bus.TX_OSET_indicate}, {9'd0, exp_ind});
        check({tag, ".rd"},   {9'd0, bus.tx_disparity},     {9'd0, exp_rd});
        check({tag, ".even"}, {9'd0, bus.tx_even},          {9'd0, exp_even});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_even      = 1'b1;
        mr_main_reset = 1'b0;
        bus.tx_o_set  = OS_I;
        bus.TXD       = 8'h00;

        repeat (3) @(posedge GTX_CLK);
        #1;
        check_reset("reset");
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;

        // Idle stream from RD-: /K28.5/D16.2/ repeating
        step("idle0_k", OS_I, 8'h00, 10'b0011111010, 1'b0, 1'b1);
        step("idle0_d", OS_I, 8'h00, 10'b1001000101, 1'b1, 1'b0);
        step("idle1_k", OS_I, 8'h00, 10'b0011111010, 1'b0, 1'b1);
        step("idle1_d", OS_I, 8'h00, 10'b1001000101, 1'b1, 1'b0);

        // Start of packet and data
        step("sop",     OS_S, 8'h00, 10'b1101101000, 1'b1, 1'b0);
        step("d01a",    OS_D, 8'h01, 10'b0111010100, 1'b1, 1'b0);
        step("d01b",    OS_D, 8'h01, 10'b0111010100, 1'b1, 1'b0);
        step("d42",     OS_D, 8'h42, 10'b1011010101, 1'b1, 1'b1);
        step("k28_rdp", OS_I, 8'h00, 10'b1100000101, 1'b0, 1'b0);
        step("i1_ign",  OS_S, 8'h55, 10'b1010010110, 1'b1, 1'b0);

        // Idle requested on an odd slot realigns with /R/
        step("sop2",    OS_S, 8'h00, 10'b1101101000, 1'b1, 1'b0);
        step("i_odd",   OS_I, 8'h00, 10'b1110101000, 1'b1, 1'b0);
        step("realn_k", OS_I, 8'h00, 10'b0011111010, 1'b0, 1'b1);
        step("realn_d", OS_I, 8'h00, 10'b1001000101, 1'b1, 1'b0);

        // Invalid codes and K-codes at both disparities
        step("os7_rdm", 3'd7, 8'h00, 10'b0111101000, 1'b1, 1'b0);
        step("d42b",    OS_D, 8'h42, 10'b1011010101, 1'b1, 1'b1);
        step("os6_rdp", 3'd6, 8'h00, 10'b1000010111, 1'b1, 1'b1);
        step("v_rdp",   OS_V, 8'h00, 10'b1000010111, 1'b1, 1'b1);
        step("t_rdp",   OS_T, 8'hFF, 10'b0100010111, 1'b1, 1'b1);
        step("r_rdp",   OS_R, 8'h00, 10'b0001010111, 1'b1, 1'b1);

        // Sub-block special cases: A7, D7 6b, 1100 4b
        step("d11_7",   OS_D, 8'hEB, 10'b1101001000, 1'b1, 1'b0);
        step("d7_3m",   OS_D, 8'h67, 10'b1110001100, 1'b1, 1'b0);
        step("d0_0",    OS_D, 8'h00, 10'b1001110100, 1'b1, 1'b0);
        step("d7_7",    OS_D, 8'hE7, 10'b1110001110, 1'b1, 1'b1);
        step("d7_3p",   OS_D, 8'h67, 10'b0001110011, 1'b1, 1'b1);

        // Reset in the middle of a data stream
        step("d9a",     OS_D, 8'h9A, 10'b0101100010, 1'b1, 1'b0);
        step("db5",     OS_D, 8'hB5, 10'b1010101010, 1'b1, 1'b0);
        bus.TXD = 8'h9A;
        #2;
        mr_main_reset = 1'b0;
        #1;
        exp_even = 1'b1;
        check_reset("rst_async");
        @(posedge GTX_CLK);
        #1;
        check_reset("rst_held");
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        step("post_k",  OS_I, 8'h00, 10'b0011111010, 1'b0, 1'b1);
        step("post_d",  OS_I, 8'h00, 10'b1001000101, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_code_group.md
TX_CODE_GROUP -- requirements
Module: tx_code_group

Interface
REQ-001 SHALL be single clock; reset is asynchronous and active-low.
REQ-002 GTX_CLK  in  1  125 MHz transmit clock; all state changes on rising edge.
REQ-003 mr_main_reset  in  1  asynchronous, active-low reset.
REQ-004 tx_o_set  in  3  ordered-set request from TX_OS: I=0, S=1, D=2, T=3, R=4, V=5; 6/7 invalid.
REQ-005 TXD  in  8  GMII data octet, used only when tx_o_set=D.
REQ-006 tx_code_group  out  10  encoded code-group, bit order abcdeifghj (a = bit 9).
REQ-007 tx_even  out  1  1 = next emitted code-group occupies an even position.
REQ-008 TX_OSET_indicate  out  1  one-cycle pulse: last code-group of the current ordered set is being emitted; upstream advances tx_o_set on this pulse.
REQ-009 tx_disparity  out  1  running disparity after current code-group (0 = RD-, 1 = RD+).

Function
REQ-010 Outputs SHALL be registered; a request sampled at edge N appears on tx_code_group after edge N (latency 1).
REQ-011 Mapping SHALL be: S=K27.7, T=K29.7, R=K23.7, V=K30.7, D=Dx.y of TXD; codes 6/7 SHALL map to K30.7.
REQ-012 FSM states SHALL be GEN_CG, IDLE_K, IDLE_D.
REQ-013 GEN_CG: when tx_o_set=I and tx_even=1, go to IDLE_K; any other request emits one code-group with TX_OSET_indicate=1.
REQ-014 A request for I with tx_even=0 SHALL emit K23.7 (/R/) with indicate=1, realigning to even.
REQ-015 IDLE_K SHALL emit K28.5 with indicate=0, then go to IDLE_D; tx_o_set ignored.
REQ-016 IDLE_D SHALL emit D5.6 (/I1/) if RD was + before the K28.5, else D16.2 (/I2/), with indicate=1, then return to GEN_CG (or IDLE_K if I is still requested).
REQ-017 tx_even SHALL toggle every cycle without exception.
REQ-018 Running disparity SHALL follow 8B/10B sub-block rules: 6b column chosen by current RD, 4b column by RD after the 6b block; RD updates after each block.
REQ-019 Exact tie: a neutral sub-block keeps RD; the 0b000111/0b111000 and 0b0011/0b1100 special cases follow the standard tables.
REQ-020 TXD SHALL be ignored outside D requests; a K-code with no valid encoding SHALL never be produced.

Reset
REQ-021 While mr_main_reset=0: tx_code_group=10'h000, tx_disparity=0, tx_even=1, TX_OSET_indicate=0, FSM=GEN_CG.
REQ-022 Reset asserted mid-ordered-set SHALL abandon it immediately; the first request after release is sampled on the first rising edge with reset high.

Structure
REQ-023 Shared package pcs_pkg SHALL hold the tx_o_set encoding, K-code constants (K28.5, K23.7, K27.7, K29.7, K30.7), D5.6/D16.2 constants and FSM state typedef.
REQ-024 Combinational sub-module enc_8b10b (inputs: octet, is_k, rd_in; outputs: code10, rd_out) SHALL hold the 5b/6b and 3b/4b tables; tx_code_group instantiates it once.

Verification
REQ-025 Reset release, tx_o_set=I held -> 0011111010, 1001000101 repeating; indicate on every second cycle; tx_disparity ends 0.
REQ-026 S at even then D 0x01 -> 1101101000 (K27.7 RD-) then 0111010100 (D1.0 RD-); indicate each cycle; tx_disparity=0.
REQ-027 D 0x42 from RD-, then I -> 1011010101 (RD+), 1100000101 (K28.5 RD+), 1010010110 (/I1/); tx_disparity=0 afterwards.
REQ-028 S at even then I on odd slot -> K27.7, then K23.7 with indicate=1, then K28.5 in even slot.
REQ-029 Reset asserted during D stream (0x9A, 0xB5) -> outputs go to reset values immediately, not clock-aligned; after release, I -> 0011111010.
REQ-030 tx_o_set=7 -> K30.7 for current RD; tx_even toggles throughout all scenarios.
